// File: rtl/ddr_line_sched_pkg.sv
// Shared types and default parameters for the display-line DDR scheduler.
package ddr_line_sched_pkg;
  localparam int LINE_WORDS_DEF = 256;
  localparam int STRIDE_DEF     = 1024;
  localparam int WR_STARVE_DEF  = 64;

  typedef logic [27:0] addr_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD_ISSUE,
    S_RD_WAIT,
    S_WR_ISSUE,
    S_WR_WAIT
  } state_e;
endpackage

// File: rtl/ddr_line_sched_arb2.sv
// Two-way grant decision: line fetch normally wins, a starved write jumps ahead once.
module ddr_arb2
  import ddr_line_sched_pkg::*;
(
  input  logic rd_pend,
  input  logic wr_pend,
  input  logic starve_hit,
  output logic grant_rd,
  output logic grant_wr
);
  assign grant_wr = wr_pend && (!rd_pend || starve_hit);
  assign grant_rd = rd_pend && !grant_wr;
endmodule

// File: rtl/ddr_line_sched.sv
// Fetches display lines from DDR into a two-bank line buffer, interleaving image-load writes.
// state      | meaning
// IDLE       | arbitrate between pending line fetch and pending write
// RD_ISSUE   | one-cycle read request for the current beat
// RD_WAIT    | wait for read data, then write it to the line buffer
// WR_ISSUE   | one-cycle write request for the latched write
// WR_WAIT    | wait for write completion, then acknowledge
module ddr_line_sched
  import ddr_line_sched_pkg::*;
#(
  parameter int LINE_WORDS = LINE_WORDS_DEF,
  parameter int STRIDE     = STRIDE_DEF,
  parameter int WR_STARVE  = WR_STARVE_DEF
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        frame_start,
  input  logic        line_start,
  input  logic        wr_req,
  input  logic [27:0] wr_addr,
  input  logic [15:0] wr_data,
  output logic        wr_ack,
  output logic        mem_req,
  output logic        mem_rnw,
  output logic [27:0] mem_addr,
  output logic [15:0] mem_din,
  input  logic [31:0] mem_dout,
  input  logic        mem_ready,
  output logic        buf_we,
  output logic [8:0]  buf_addr,
  output logic [31:0] buf_data,
  output logic        underrun,
  output logic [7:0]  drop_cnt,
  output logic        busy
);
  localparam logic [7:0]  LAST_BEAT  = 8'(LINE_WORDS - 1);
  localparam logic [15:0] STARVE_LIM = 16'(WR_STARVE);
  localparam addr_t       STRIDE_A   = addr_t'(STRIDE);

  state_e      state_q, state_d;
  addr_t       line_base_q, line_base_d, wr_addr_q;
  logic [15:0] wr_data_q;
  logic        bank_q, bank_d;
  logic [7:0]  beat_q, beat_d;
  logic [1:0]  pend_q, pend_d;
  logic [15:0] starve_q, starve_d;
  logic        wr_pend_q, wr_pend_d;
  logic        abort_q, abort_d;
  logic        underrun_q, underrun_d;
  logic [7:0]  drop_q, drop_d;
  logic        grant_rd, grant_wr, rd_done, wr_done, kill, ls_ok, fetch_end, is_wr;

  assign rd_done   = (state_q == S_RD_WAIT) && mem_ready;
  assign wr_done   = (state_q == S_WR_WAIT) && mem_ready;
  // A new frame kills the in-flight beat, whether it arrives now or arrived earlier.
  assign kill      = abort_q || frame_start;
  assign ls_ok     = line_start && !frame_start;
  assign fetch_end = rd_done && !kill && (beat_q == LAST_BEAT);
  assign is_wr     = (state_q == S_WR_ISSUE) || (state_q == S_WR_WAIT);

  ddr_arb2 u_arb (
    .rd_pend    (pend_q != 2'd0),
    .wr_pend    (wr_pend_q),
    .starve_hit (starve_q >= STARVE_LIM),
    .grant_rd   (grant_rd),
    .grant_wr   (grant_wr)
  );

  always_comb begin
    state_d     = state_q;
    line_base_d = line_base_q;
    bank_d      = bank_q;
    beat_d      = beat_q;
    pend_d      = pend_q;
    starve_d    = starve_q;
    wr_pend_d   = wr_pend_q;
    abort_d     = abort_q;
    underrun_d  = underrun_q;
    drop_d      = drop_q;

    case (state_q)
      S_IDLE:     if (grant_wr) state_d = S_WR_ISSUE;
                  else if (grant_rd) state_d = S_RD_ISSUE;
      S_RD_ISSUE: state_d = S_RD_WAIT;
      S_RD_WAIT:  if (mem_ready) state_d = S_IDLE;
      S_WR_ISSUE: state_d = S_WR_WAIT;
      S_WR_WAIT:  if (mem_ready) state_d = S_IDLE;
      default:    state_d = S_IDLE;
    endcase

    if (rd_done) abort_d = 1'b0;
    else if (frame_start && (state_q == S_RD_ISSUE || state_q == S_RD_WAIT)) abort_d = 1'b1;

    if (frame_start) begin
      line_base_d = '0;
      bank_d      = 1'b0;
      beat_d      = '0;
      pend_d      = 2'd1;
      underrun_d  = 1'b0;
    end else begin
      if (rd_done && !kill) begin
        if (beat_q == LAST_BEAT) begin
          beat_d      = '0;
          line_base_d = line_base_q + STRIDE_A;
          bank_d      = ~bank_q;
        end else begin
          beat_d = beat_q + 8'd1;
        end
      end
      if (fetch_end) pend_d = pend_q - 2'd1;
      if (ls_ok) begin
        if (pend_q != 2'd0) underrun_d = 1'b1;
        if (pend_q == 2'd2) drop_d = (drop_q == 8'hFF) ? drop_q : drop_q + 8'd1;
        else pend_d = pend_d + 2'd1;
      end
    end

    if (state_q == S_IDLE && grant_wr) starve_d = '0;
    else if (!wr_pend_q) starve_d = '0;
    else if (rd_done && starve_q < STARVE_LIM) starve_d = starve_q + 16'd1;

    if (wr_done) wr_pend_d = 1'b0;
    else if (wr_req) wr_pend_d = 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      line_base_q <= '0;
      bank_q      <= 1'b0;
      beat_q      <= '0;
      pend_q      <= '0;
      starve_q    <= '0;
      wr_pend_q   <= 1'b0;
      abort_q     <= 1'b0;
      underrun_q  <= 1'b0;
      drop_q      <= '0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
    end else begin
      state_q     <= state_d;
      line_base_q <= line_base_d;
      bank_q      <= bank_d;
      beat_q      <= beat_d;
      pend_q      <= pend_d;
      starve_q    <= starve_d;
      wr_pend_q   <= wr_pend_d;
      abort_q     <= abort_d;
      underrun_q  <= underrun_d;
      drop_q      <= drop_d;
      if (wr_req && !wr_pend_q) begin
        wr_addr_q <= wr_addr;
        wr_data_q <= wr_data;
      end
    end
  end

  assign mem_req  = (state_q == S_RD_ISSUE) || (state_q == S_WR_ISSUE);
  assign mem_rnw  = !is_wr;
  assign mem_addr = is_wr ? wr_addr_q : line_base_q + {18'd0, beat_q, 2'b00};
  assign mem_din  = wr_data_q;
  assign buf_we   = rd_done && !kill;
  assign buf_addr = {bank_q, beat_q};
  assign buf_data = mem_dout;
  assign wr_ack   = wr_done;
  assign underrun = underrun_q;
  assign drop_cnt = drop_q;
  assign busy     = (state_q != S_IDLE);
endmodule

// File: tb/tb_ddr_line_sched.sv
// Directed bench: scoreboard of expected DDR requests and line-buffer writes, checked as the DUT emits them.
module tb_ddr_line_sched;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_n, frame_start, line_start, wr_req;
  logic [27:0] wr_addr;
  logic [15:0] wr_data;
  logic        rsp_ready, man_ready, mem_ready;
  logic [31:0] rsp_dout, man_dout, mem_dout;
  logic        wr_ack, mem_req, mem_rnw, buf_we, underrun, busy;
  logic [27:0] mem_addr;
  logic [15:0] mem_din;
  logic [8:0]  buf_addr;
  logic [31:0] buf_data;
  logic [7:0]  drop_cnt;

  assign mem_ready = rsp_ready | man_ready;
  assign mem_dout  = rsp_dout | man_dout;

  ddr_line_sched dut (
    .clk(clk), .reset_n(reset_n), .frame_start(frame_start), .line_start(line_start),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ack(wr_ack),
    .mem_req(mem_req), .mem_rnw(mem_rnw), .mem_addr(mem_addr), .mem_din(mem_din),
    .mem_dout(mem_dout), .mem_ready(mem_ready), .buf_we(buf_we), .buf_addr(buf_addr),
    .buf_data(buf_data), .underrun(underrun), .drop_cnt(drop_cnt), .busy(busy)
  );

  // Second instance with a huge stride and short lines, to exercise address wrap cheaply.
  logic        frame_start_w, line_start_w, wr_req_w, ready_w;
  logic [27:0] wr_addr_w;
  logic [15:0] wr_data_w;
  logic [31:0] dout_w;
  logic        wr_ack_w, mem_req_w, mem_rnw_w, buf_we_w, underrun_w, busy_w;
  logic [27:0] mem_addr_w;
  logic [15:0] mem_din_w;
  logic [8:0]  buf_addr_w;
  logic [31:0] buf_data_w;
  logic [7:0]  drop_cnt_w;

  ddr_line_sched #(.LINE_WORDS(2), .STRIDE(32'h0800_0000), .WR_STARVE(64)) u_wrap (
    .clk(clk), .reset_n(reset_n), .frame_start(frame_start_w), .line_start(line_start_w),
    .wr_req(wr_req_w), .wr_addr(wr_addr_w), .wr_data(wr_data_w), .wr_ack(wr_ack_w),
    .mem_req(mem_req_w), .mem_rnw(mem_rnw_w), .mem_addr(mem_addr_w), .mem_din(mem_din_w),
    .mem_dout(dout_w), .mem_ready(ready_w), .buf_we(buf_we_w), .buf_addr(buf_addr_w),
    .buf_data(buf_data_w), .underrun(underrun_w), .drop_cnt(drop_cnt_w), .busy(busy_w)
  );

  typedef struct packed {
    logic        rnw;
    logic [27:0] addr;
    logic [15:0] din;
  } req_t;

  req_t        exp_req[$];
  logic [40:0] exp_buf[$];
  req_t        e_r;
  logic [40:0] e_b;
  logic [27:0] rsp_addr;
  int          n_pass = 0;
  int          n_total = 0;
  int          ack_seen = 0;
  bit          resp_en = 1'b1;

  function automatic logic [31:0] mem_word(input logic [27:0] a);
    return 32'hD000_0000 ^ {4'h0, a};
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic timeout(input string tag);
    n_total++;
    $error("FAIL %s: timed out, %0d reqs / %0d buf writes still expected", tag, exp_req.size(), exp_buf.size());
  endtask

  task automatic push_line(input logic [27:0] base, input logic bank, input int first,
                           input int nreq, input int nbuf);
    for (int k = first; k < first + nreq; k++)
      exp_req.push_back('{1'b1, base + 28'(4 * k), 16'h0});
    for (int k = first; k < first + nbuf; k++)
      exp_buf.push_back({bank, 8'(k), mem_word(base + 28'(4 * k))});
  endtask

  task automatic pulse(input int which);
    @(posedge clk); #1;
    case (which)
      0: frame_start = 1'b1;
      1: line_start = 1'b1;
      2: frame_start_w = 1'b1;
      default: line_start_w = 1'b1;
    endcase
    @(posedge clk); #1;
    frame_start = 1'b0; line_start = 1'b0; frame_start_w = 1'b0; line_start_w = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    do begin @(negedge clk); n++; end
    while (!(exp_req.size() == 0 && exp_buf.size() == 0 && !busy) && n < 8000);
    if (n >= 8000) timeout(tag);
    repeat (8) @(negedge clk);
    check({tag, " busy after drain"}, busy, 0);
  endtask

  task automatic wait_req(input logic [27:0] a, input string tag);
    int n = 0;
    do begin @(negedge clk); n++; end
    while (!(mem_req && mem_addr == a) && n < 8000);
    if (n >= 8000) timeout(tag);
  endtask

  task automatic serve_w(input logic [27:0] ea, input logic [8:0] eb, input string tag);
    int n = 0;
    do begin @(negedge clk); n++; end
    while (!mem_req_w && n < 100);
    if (n >= 100) timeout(tag);
    check({tag, " addr"}, mem_addr_w, ea);
    @(posedge clk); #1 ready_w = 1'b1;
    @(negedge clk);
    check({tag, " buf_we"}, buf_we_w, 1);
    check({tag, " buf_addr"}, buf_addr_w, eb);
    @(posedge clk); #1 ready_w = 1'b0;
  endtask

  // DDR model: answers each request three cycles later with address-derived data.
  initial begin
    rsp_ready = 1'b0;
    rsp_dout  = '0;
    forever begin
      @(negedge clk);
      if (mem_req && resp_en && reset_n) begin
        rsp_addr = mem_addr;
        repeat (3) @(posedge clk);
        #1 rsp_ready = 1'b1;
        rsp_dout = mem_word(rsp_addr);
        @(posedge clk);
        #1 rsp_ready = 1'b0;
        rsp_dout = '0;
      end
    end
  end

  // Scoreboard monitor.
  initial begin
    forever begin
      @(negedge clk);
      if (reset_n) begin
        if (mem_req) begin
          if (exp_req.size() == 0) begin
            n_total++;
            $error("FAIL unexpected mem_req: addr 0x%0h rnw %0b, none expected", mem_addr, mem_rnw);
          end else begin
            e_r = exp_req.pop_front();
            check("mem_rnw", mem_rnw, e_r.rnw);
            check("mem_addr", mem_addr, e_r.addr);
            if (!e_r.rnw) check("mem_din", mem_din, e_r.din);
          end
        end
        if (buf_we) begin
          if (exp_buf.size() == 0) begin
            n_total++;
            $error("FAIL unexpected buf_we: buf_addr 0x%0h, none expected", buf_addr);
          end else begin
            e_b = exp_buf.pop_front();
            check("buf_addr", buf_addr, e_b[40:32]);
            check("buf_data", buf_data, e_b[31:0]);
          end
        end
        if (wr_ack) ack_seen++;
      end
    end
  end

  initial begin
    #900_000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_total);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    reset_n = 1'b0; frame_start = 1'b0; line_start = 1'b0; wr_req = 1'b0;
    wr_addr = '0; wr_data = '0; man_ready = 1'b0; man_dout = '0;
    frame_start_w = 1'b0; line_start_w = 1'b0; wr_req_w = 1'b0;
    wr_addr_w = '0; wr_data_w = '0; ready_w = 1'b0; dout_w = 32'h1234_5678;

    repeat (3) @(negedge clk);
    check("rst mem_req", mem_req, 0);
    check("rst buf_we", buf_we, 0);
    check("rst wr_ack", wr_ack, 0);
    check("rst underrun", underrun, 0);
    check("rst busy", busy, 0);
    check("rst drop_cnt", drop_cnt, 0);
    @(posedge clk); #1 reset_n = 1'b1;
    repeat (3) @(negedge clk);

    // One full line fetch, with request latency after frame_start.
    push_line(28'h0, 1'b0, 0, 256, 256);
    pulse(0);
    @(negedge clk);
    check("latency cycle1 mem_req", mem_req, 0);
    @(negedge clk);
    check("latency cycle2 mem_req", mem_req, 1);
    wait_idle("single fetch");
    check("single fetch underrun", underrun, 0);

    // Line starts during a fetch: queue, underrun, drop; second line into bank 1.
    push_line(28'h0, 1'b0, 0, 256, 256);
    push_line(28'h400, 1'b1, 0, 256, 256);
    push_line(28'h800, 1'b0, 0, 256, 256);
    pulse(0);
    repeat (50) @(negedge clk);
    pulse(1);
    @(negedge clk);
    check("queue underrun", underrun, 1);
    check("queue drop_cnt", drop_cnt, 0);
    pulse(1);
    @(negedge clk);
    check("drop drop_cnt", drop_cnt, 1);
    n = 0;
    while (exp_buf.size() > 512 && n < 4000) begin @(negedge clk); n++; end
    if (n >= 4000) timeout("first fetch end");
    pulse(1);
    wait_idle("queued fetches");
    check("final drop_cnt", drop_cnt, 1);
    check("final underrun", underrun, 1);

    // Write waiting through a fetch is granted after 64 read beats.
    push_line(28'h0, 1'b0, 0, 64, 0);
    exp_req.push_back('{1'b0, 28'h10, 16'hBEEF});
    push_line(28'h0, 1'b0, 64, 192, 0);
    push_line(28'h0, 1'b0, 0, 0, 256);
    wr_addr = 28'h10; wr_data = 16'hBEEF;
    pulse(0);
    wr_req = 1'b1;
    @(negedge clk);
    check("frame clears underrun", underrun, 0);
    n = 0;
    while (!wr_ack && n < 2000) begin @(negedge clk); n++; end
    if (n >= 2000) timeout("wr_ack");
    wr_req = 1'b0;
    wait_idle("starved write");
    check("wr_ack count", ack_seen, 1);

    // Lines 0..4, then abort line 5 at beat 100 with a new frame.
    push_line(28'h0, 1'b0, 0, 256, 256);
    pulse(0);
    for (int l = 1; l <= 4; l++) begin
      wait_idle("line walk");
      push_line(28'(l * 1024), 1'(l % 2), 0, 256, 256);
      pulse(1);
    end
    wait_idle("line 4");
    push_line(28'h1400, 1'b1, 0, 101, 100);
    push_line(28'h0, 1'b0, 0, 256, 256);
    pulse(1);
    wait_req(28'h1400 + 28'd200, "line5 beat50");
    pulse(1);
    @(negedge clk);
    check("line5 underrun set", underrun, 1);
    wait_req(28'h1400 + 28'd400, "line5 beat100");
    frame_start = 1'b1;
    @(posedge clk); #1 frame_start = 1'b0;
    @(negedge clk);
    check("abort underrun cleared", underrun, 0);
    wait_idle("abort refetch");

    // Reset during RD_WAIT; late mem_ready afterwards is ignored.
    resp_en = 1'b0;
    exp_req.push_back('{1'b1, 28'h0, 16'h0});
    pulse(0);
    wait_req(28'h0, "reset beat0");
    @(posedge clk); #1 reset_n = 1'b0;
    @(negedge clk);
    check("mid rst mem_req", mem_req, 0);
    check("mid rst buf_we", buf_we, 0);
    check("mid rst wr_ack", wr_ack, 0);
    check("mid rst underrun", underrun, 0);
    check("mid rst busy", busy, 0);
    check("mid rst drop_cnt", drop_cnt, 0);
    @(posedge clk); #1 reset_n = 1'b1;
    @(posedge clk); #1 man_ready = 1'b1; man_dout = 32'hCAFE_F00D;
    @(negedge clk);
    check("late ready buf_we", buf_we, 0);
    check("late ready busy", busy, 0);
    @(posedge clk); #1 man_ready = 1'b0; man_dout = '0;
    repeat (6) @(negedge clk);
    check("post rst busy", busy, 0);
    check("post rst mem_req", mem_req, 0);
    resp_en = 1'b1;

    // Address wrap modulo 2^28 on the short-line instance.
    pulse(2);
    serve_w(28'h0, 9'h000, "wrap l0b0");
    serve_w(28'h4, 9'h001, "wrap l0b1");
    pulse(3);
    serve_w(28'h800_0000, 9'h100, "wrap l1b0");
    serve_w(28'h800_0004, 9'h101, "wrap l1b1");
    pulse(3);
    serve_w(28'h0, 9'h000, "wrap l2b0");
    serve_w(28'h4, 9'h001, "wrap l2b1");
    repeat (4) @(negedge clk);
    check("wrap busy", busy_w, 0);
    check("wrap wr_ack", wr_ack_w, 0);

    check("end wr_ack count", ack_seen, 1);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
